// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiplier job dispatcher.
// Holds the controller state encoding and the default core/row sizing.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        FINISH   = 2'd3
    } mm_state_e;

    localparam int MM_NUM_CORES_DEF = 4;
    localparam int MM_ROW_W_DEF     = 8;
    localparam int MM_ROW_T_W       = MM_ROW_W_DEF;

    typedef logic [MM_ROW_T_W-1:0] mm_row_t;

endpackage

// File: rtl/mm_prio_pick.sv
// Lowest-index one-hot selector: grants the least significant requesting bit.
module mm_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_grant,
    output logic         o_valid
);

    // isolate the lowest set bit with the two's-complement trick
    always_comb begin
        o_grant = i_req & (~i_req + N'(1));
        o_valid = |i_req;
    end

endmodule

// File: rtl/mm_row_dispatcher.sv
// Splits a multiply job into result rows and hands them to NUM_CORES cores,
// tracking per-core busy state and signalling job completion.
module mm_row_dispatcher
    import mm_pkg::*;
#(
    parameter int NUM_CORES = MM_NUM_CORES_DEF,
    parameter int ROW_W     = MM_ROW_W_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [ROW_W-1:0]           i_rows,
    input  logic                       i_mode,
    input  logic [NUM_CORES-1:0]       i_core_done,
    output logic [NUM_CORES-1:0]       o_core_start,
    output logic [NUM_CORES*ROW_W-1:0] o_core_row,
    output logic [NUM_CORES-1:0]       o_busy,
    output logic                       o_active,
    output logic                       o_done
);

    localparam int CW = ROW_W + 1;

    mm_state_e                  state_r, state_nxt_s;
    logic                       start_prev_r, start_edge_s, launch_s;
    logic                       dispatching_s, all_issued_s, pick_valid_s;
    logic                       mode_r, mode_eff_s;
    logic [ROW_W-1:0]           rows_r, rows_eff_s, rows_done_r, rows_done_nxt_s;
    logic [CW-1:0]              next_row_r, next_row_eff_s, next_row_nxt_s;
    logic [CW-1:0]              row_cnt_r     [NUM_CORES];
    logic [CW-1:0]              row_cnt_eff_s [NUM_CORES];
    logic [CW-1:0]              row_cnt_nxt_s [NUM_CORES];
    logic [NUM_CORES-1:0]       busy_r, busy_eff_s, accepted_s, have_row_s;
    logic [NUM_CORES-1:0]       left_s, eligible_s, grant_s, core_start_r;
    logic [NUM_CORES*ROW_W-1:0] core_row_r;
    logic                       active_r, done_r;

    function automatic logic [ROW_W-1:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [ROW_W-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cnt = cnt + ROW_W'(v[k]);
        end
        return cnt;
    endfunction

    // Launch detection and eligibility; the launch cycle already dispatches,
    // so it works on the incoming job parameters instead of the latched ones.
    always_comb begin
        start_edge_s    = i_start & ~start_prev_r;
        launch_s        = (state_r == IDLE) && start_edge_s;
        dispatching_s   = (state_r == DISPATCH) || (launch_s && (i_rows != '0));
        rows_eff_s      = launch_s ? i_rows : rows_r;
        mode_eff_s      = launch_s ? i_mode : mode_r;
        next_row_eff_s  = launch_s ? '0 : next_row_r;
        accepted_s      = i_core_done & busy_r;
        busy_eff_s      = (busy_r & ~accepted_s) | core_start_r;
        rows_done_nxt_s = rows_done_r + popcount(accepted_s);
        for (int k = 0; k < NUM_CORES; k++) begin
            row_cnt_eff_s[k] = launch_s ? CW'(k) : row_cnt_r[k];
            have_row_s[k]    = mode_eff_s ? (next_row_eff_s < {1'b0, rows_eff_s})
                                          : (row_cnt_eff_s[k] < {1'b0, rows_eff_s});
            left_s[k]        = row_cnt_r[k] < {1'b0, rows_r};
        end
        eligible_s   = dispatching_s ? (~busy_eff_s & have_row_s) : '0;
        all_issued_s = mode_r ? (next_row_r >= {1'b0, rows_r}) : ~|left_s;
    end

    mm_prio_pick #(
        .N (NUM_CORES)
    ) u_pick (
        .i_req   (eligible_s),
        .o_grant (grant_s),
        .o_valid (pick_valid_s)
    );

    // Row counter advance for whichever core won this cycle
    always_comb begin
        next_row_nxt_s = next_row_eff_s + ((pick_valid_s && mode_eff_s) ? CW'(1) : CW'(0));
        for (int k = 0; k < NUM_CORES; k++) begin
            row_cnt_nxt_s[k] = row_cnt_eff_s[k]
                             + ((grant_s[k] && !mode_eff_s) ? CW'(NUM_CORES) : CW'(0));
        end
    end

    // Job-level next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = (i_rows == '0) ? FINISH : DISPATCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DISPATCH: begin
                if (all_issued_s) begin
                    state_nxt_s = (rows_done_nxt_s == rows_r) ? FINISH : DRAIN;
                end else begin
                    state_nxt_s = DISPATCH;
                end
            end
            DRAIN: begin
                if (rows_done_nxt_s == rows_r) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            FINISH:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Controller state, job parameters and counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= IDLE;
            start_prev_r <= 1'b0;
            rows_r       <= '0;
            mode_r       <= 1'b0;
            next_row_r   <= '0;
            rows_done_r  <= '0;
            active_r     <= 1'b0;
            done_r       <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) begin
                row_cnt_r[k] <= '0;
            end
        end else begin
            state_r      <= state_nxt_s;
            start_prev_r <= i_start;
            rows_r       <= rows_eff_s;
            mode_r       <= mode_eff_s;
            next_row_r   <= next_row_nxt_s;
            rows_done_r  <= launch_s ? '0 : rows_done_nxt_s;
            active_r     <= (state_nxt_s != IDLE);
            done_r       <= (state_nxt_s == FINISH);
            for (int k = 0; k < NUM_CORES; k++) begin
                row_cnt_r[k] <= row_cnt_nxt_s[k];
            end
        end
    end

    // Per-core start pulse, busy flag and row slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_r       <= '0;
            core_start_r <= '0;
            core_row_r   <= '0;
        end else begin
            busy_r       <= busy_eff_s;
            core_start_r <= grant_s;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (grant_s[k]) begin
                    core_row_r[k*ROW_W +: ROW_W] <= mode_eff_s ? next_row_eff_s[ROW_W-1:0]
                                                               : row_cnt_eff_s[k][ROW_W-1:0];
                end
            end
        end
    end

    assign o_core_start = core_start_r;
    assign o_core_row   = core_row_r;
    assign o_busy       = busy_r;
    assign o_active     = active_r;
    assign o_done       = done_r;

endmodule

// File: tb/tb_mm_row_dispatcher.sv
// Scoreboard bench for mm_row_dispatcher: expected (core,row) starts are queued
// per job, cores are modelled with per-core latencies, and o_done timing is checked.
module tb_mm_row_dispatcher;

    localparam int N  = 4;
    localparam int RW = 8;

    logic            clk_s = 1'b0;
    logic            rst_n_s;
    logic            start_s;
    logic [RW-1:0]   rows_s;
    logic            mode_s;
    logic [N-1:0]    core_done_s;
    logic [N-1:0]    core_start_s;
    logic [N*RW-1:0] core_row_s;
    logic [N-1:0]    busy_s;
    logic            active_s;
    logic            done_s;

    typedef struct {
        int core;
        int row;
    } exp_t;

    exp_t         exp_q[$];
    int           lat[N];
    int           cnt[N];
    logic [N-1:0] spur_s;
    logic [N-1:0] prev_start_s;
    int           cyc, n_chk, n_pass;
    int           dones_drv, last_done_cyc, done_pulses, done_cyc;

    always #5 clk_s = ~clk_s;

    mm_row_dispatcher #(
        .NUM_CORES (N),
        .ROW_W     (RW)
    ) dut (
        .i_clk        (clk_s),
        .i_rst_n      (rst_n_s),
        .i_start      (start_s),
        .i_rows       (rows_s),
        .i_mode       (mode_s),
        .i_core_done  (core_done_s),
        .o_core_start (core_start_s),
        .o_core_row   (core_row_s),
        .o_busy       (busy_s),
        .o_active     (active_s),
        .o_done       (done_s)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c, input int r);
        exp_t e;
        e.core = c;
        e.row  = r;
        exp_q.push_back(e);
    endtask

    // One clock: sample outputs #1 after the edge, then model the cores.
    task automatic step();
        logic [N-1:0] d;
        exp_t         e;
        @(posedge clk_s);
        #1;
        cyc++;
        if (prev_start_s != '0) begin
            check_val("busy_after_start", 64'(busy_s & prev_start_s), 64'(prev_start_s));
        end
        d      = spur_s;
        spur_s = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt[k] > 0) begin
                cnt[k]--;
                if (cnt[k] == 0) begin
                    d[k]          = 1'b1;
                    dones_drv++;
                    last_done_cyc = cyc;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (core_start_s[k]) begin
                if (exp_q.size() == 0) begin
                    check_val("start_queued", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("start_core", 64'(k), 64'(e.core));
                    check_val("start_row", 64'(core_row_s[k*RW +: RW]), 64'(e.row));
                end
                cnt[k] = lat[k];
            end
        end
        prev_start_s = core_start_s;
        if (done_s) begin
            done_pulses++;
            done_cyc = cyc;
        end
        core_done_s = d;
    endtask

    task automatic do_job(input int rows, input logic mode, input logic hold,
                          input int toggle_at, input int spur_at, input int spur_core);
        int launch_cyc;
        int exp_done;
        start_s = 1'b0;
        step();
        done_pulses = 0;
        dones_drv   = 0;
        rows_s      = RW'(rows);
        mode_s      = mode;
        start_s     = 1'b1;
        step();
        launch_cyc = cyc;
        check_val("launch_active", 64'(active_s), 64'd1);
        rows_s = 8'd255;
        mode_s = ~mode;
        if (!hold) begin
            start_s = 1'b0;
        end
        for (int i = 1; i < 80 && done_pulses == 0; i++) begin
            if (i == toggle_at)     start_s = 1'b0;
            if (i == toggle_at + 1) start_s = 1'b1;
            if (i == spur_at)       spur_s[spur_core] = 1'b1;
            step();
        end
        check_val("done_seen", 64'(done_pulses), 64'd1);
        exp_done = (rows == 0) ? launch_cyc : last_done_cyc + 1;
        check_val("done_cycle", 64'(done_cyc), 64'(exp_done));
        check_val("done_active", 64'(active_s), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check_val("done_once", 64'(done_pulses), 64'd1);
        check_val("idle_after", 64'(active_s), 64'd0);
        check_val("rows_returned", 64'(dones_drv), 64'(rows));
        check_val("starts_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
        lat[3] = l3;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        dones_drv = 0; last_done_cyc = 0; done_pulses = 0; done_cyc = 0;
        rst_n_s = 1'b0; start_s = 1'b0; rows_s = '0; mode_s = 1'b0;
        core_done_s = '0; spur_s = '0; prev_start_s = '0;
        for (int k = 0; k < N; k++) begin
            cnt[k] = 0;
            lat[k] = 3;
        end
        step();
        step();
        check_val("rst_start", 64'(core_start_s), 64'd0);
        check_val("rst_row", 64'(core_row_s), 64'd0);
        check_val("rst_busy", 64'(busy_s), 64'd0);
        check_val("rst_active", 64'(active_s), 64'd0);
        check_val("rst_done", 64'(done_s), 64'd0);
        rst_n_s = 1'b1;
        step();

        // dynamic, rows=6, every core takes 3 cycles
        set_lat(3, 3, 3, 3);
        push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 3);
        push_exp(0, 4); push_exp(1, 5);
        do_job(6, 1'b1, 1'b0, 0, 0, 0);

        // static, rows=6, core 3 stalls
        set_lat(3, 3, 3, 20);
        push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 3);
        push_exp(0, 4); push_exp(1, 5);
        do_job(6, 1'b0, 1'b0, 0, 0, 0);

        // static, core 0 fast: it still only owns rows 0 and 4
        set_lat(1, 9, 9, 9);
        push_exp(0, 0); push_exp(1, 1); push_exp(0, 4); push_exp(2, 2); push_exp(3, 3);
        do_job(5, 1'b0, 1'b0, 0, 0, 0);

        // zero-row job
        do_job(0, 1'b1, 1'b0, 0, 0, 0);

        // all four dones in the same cycle
        set_lat(6, 5, 4, 3);
        push_exp(0, 0); push_exp(1, 1); push_exp(2, 2); push_exp(3, 3);
        do_job(4, 1'b1, 1'b0, 0, 0, 0);

        // spurious done on idle core 3
        set_lat(3, 3, 3, 3);
        push_exp(0, 0); push_exp(1, 1);
        do_job(2, 1'b1, 1'b0, 0, 1, 3);

        // start held high across job end, with a 0->1 toggle mid-job
        push_exp(0, 0); push_exp(1, 1); push_exp(2, 2);
        do_job(3, 1'b1, 1'b1, 2, 0, 0);
        push_exp(0, 0); push_exp(1, 1);
        do_job(2, 1'b1, 1'b0, 0, 0, 0);

        // reset asserted mid-dispatch, then a fresh job
        start_s = 1'b0;
        step();
        done_pulses = 0;
        rows_s = 8'd6; mode_s = 1'b1;
        push_exp(0, 0); push_exp(1, 1);
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        step();
        rst_n_s = 1'b0;
        core_done_s = '0;
        prev_start_s = '0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        step();
        check_val("mid_rst_start", 64'(core_start_s), 64'd0);
        check_val("mid_rst_row", 64'(core_row_s), 64'd0);
        check_val("mid_rst_busy", 64'(busy_s), 64'd0);
        check_val("mid_rst_active", 64'(active_s), 64'd0);
        check_val("mid_rst_no_done", 64'(done_pulses), 64'd0);
        check_val("mid_rst_starts", 64'(exp_q.size()), 64'd0);
        step();
        rst_n_s = 1'b1;
        step();
        push_exp(0, 0); push_exp(1, 1);
        do_job(2, 1'b1, 1'b0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mm_row_dispatcher.md
# mm_row_dispatcher

Parametrised job controller for the matrix-multiplier top: it splits one multiply job into result rows and hands them out to `NUM_CORES` multiply cores. Each core gets a start pulse with a row index, and the dispatcher tracks each core's busy/done state. It is the generalised successor of the fixed four-core `start`/`busy` arrangement: core count and row width are parameters, rows can be scheduled in two modes, and job completion is reported explicitly. It sits between the top-level `i_start` input and the core array.

## Interface
- `NUM_CORES`, default 4: number of multiply cores, range 1..16.
- `ROW_W`, default 8: row-index width; the maximum job is 2^ROW_W−1 rows.

- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_start` in 1: level input; a job launches on its 0→1 transition.
- `i_rows` in ROW_W: number of result rows, latched at launch.
- `i_mode` in 1: scheduling mode, latched at launch.
  - 0 = static interleave.
  - 1 = dynamic (any idle core).
- `i_core_done` in NUM_CORES: per-core one-cycle completion pulse.
- `o_core_start` out NUM_CORES: per-core one-cycle start pulse.
- `o_core_row` out NUM_CORES*ROW_W: row index for each core, held stable while that core is busy.
- `o_busy` out NUM_CORES: per-core busy flag.
- `o_active` out 1: a job is in progress.
- `o_done` out 1: one-cycle pulse when every row of the job has completed.

## Operation
- FSM states: IDLE, DISPATCH, DRAIN, FINISH.
- IDLE → DISPATCH on a rising `i_start` edge (registered previous value, reset to 0).
  - On that edge, latch `i_rows` and `i_mode`, and clear all counters.
  - If `i_rows` == 0, go IDLE → FINISH instead.
- DISPATCH: each cycle, pick the lowest-index *eligible* core and assign it one row. Rules:
  - A core is eligible when `o_busy[k]`=0 and it has a row left to take.
  - Dynamic mode: the row is the global `next_row`, which then increments.
  - Static mode: core k owns rows k, k+N, k+2N, … and keeps its own counter `row_k` (ROW_W+1 bits, no wrap). Core k is eligible while `row_k` < rows.
  - At most one assignment per cycle.
  - The assignment drives `o_core_start[k]`=1 and loads the core's `o_core_row` slot.
- DISPATCH → DRAIN once all rows have been issued.
- DRAIN → FINISH when `rows_done` == rows.
  - `rows_done` is ROW_W bits and increments once per accepted done.
- FINISH: `o_done`=1 for one cycle, then go to IDLE.
- `i_core_done[k]` handling:
  - If `o_busy[k]`=1, it clears busy and counts one row done.
  - If `o_busy[k]`=0, it is ignored and not counted.
  - Several simultaneous dones all count in the same cycle (popcount).
- A rising `i_start` edge while `o_active`=1 is ignored. A held-high `i_start` does not relaunch.

## Timing
- Reset values: all outputs 0, `o_core_row` all zero, state IDLE.
- Launch:
  - Edge sampled at clock n.
  - `o_active`=1 from cycle n+1.
  - First `o_core_start` in cycle n+1.
- `o_core_start[k]` in cycle t → `o_busy[k]`=1 from t+1. `o_core_row` is valid in cycle t.
- A done sampled at clock t → busy cleared at t+1 → the core can be reassigned in cycle t+1 (start pulse in t+1).
- Last done sampled at clock t → `o_done` high in cycle t+1 with `o_active` still 1 → `o_active`=0 at t+2.
- Zero-row job: `o_done` in cycle n+1, no core starts.
- Reset asserted mid-job: everything clears immediately, with no `o_done`. Cores must be reset by the same `i_rst_n`.

## Structure
- Package `mm_pkg` holds:
  - the state enum (IDLE/DISPATCH/DRAIN/FINISH);
  - default `NUM_CORES` and `ROW_W`;
  - the `mm_row_t` width constant.
- Sub-module `mm_prio_pick`: parametrised lowest-index one-hot selector over the eligible vector, returning a one-hot grant plus a valid flag.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-DISPATCH → all outputs 0 next edge; release, pulse `i_start` → fresh job from row 0.
- **Dynamic, N=4, rows=6, cores finish in 3 cycles:**
  - starts go to cores 0,1,2,3 on consecutive cycles with rows 0,1,2,3;
  - rows 4 and 5 go to the first cores freed;
  - exactly one `o_done`, after the 6th done.
- **Static, N=4, rows=6, core 3 stalls:**
  - core 0 gets rows 0,4;
  - core 1 gets rows 1,5;
  - core 2 gets row 2 only;
  - `o_done` only after core 3 returns row 3.
- **Rows=0:** `o_done` in cycle after launch; `o_core_start` never asserts.
- **Simultaneous and spurious dones:**
  - all four cores pulse `i_core_done` together → `rows_done` += 4;
  - done pulsed on an idle core → ignored, `o_done` timing unchanged.
- **Start behaviour:**
  - `i_start` held high across job end → no relaunch;
  - toggle 0→1 during an active job → ignored;
  - toggle after `o_done` → new job with newly latched `i_rows`=2.
